// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NREQ producers.
// Each write is confirmed by the FIFO's registered ack and retried on rejection.
// Optional build macro FIFO_ARB_ALMOSTFULL_THROTTLE_EN also treats almostfull as blocking.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_done,
    output logic [$clog2(NREQ)-1:0]    gnt_id,
    output logic                       busy,
    output logic [7:0]                 retry_cnt,
    output logic [DATA_WIDTH-1:0]      fifo_data_in,
    output logic                       fifo_wr_en,
    input  logic                       fifo_full,
    input  logic                       fifo_almostfull,
    input  logic                       fifo_wr_ack,
    output logic [1:0]                 dbg_state
);
    localparam int GW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CHECK = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_gnt;
    logic [GW-1:0]         r_last;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NREQ-1:0]       r_done;
    logic [7:0]            r_retry;

    logic [NREQ-1:0]       w_elig;
    logic                  w_blocked;
    logic                  w_found;
    logic [GW-1:0]         w_sel;
    logic [GW-1:0]         w_cand;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_load;
    logic                  w_retry_inc;
    logic [NREQ-1:0]       w_done_nxt;

    // Handshake: a producer raises req with its word on req_data and holds it until
    // req_done pulses for one cycle; the word is captured once, at grant time.
    assign w_elig = req & ~r_done;

`ifdef FIFO_ARB_ALMOSTFULL_THROTTLE_EN
    assign w_blocked = fifo_full | fifo_almostfull;
`else
    logic w_unused_almostfull;
    assign w_unused_almostfull = fifo_almostfull;
    assign w_blocked = fifo_full;
`endif

    // Search starts one past the last grant so every requester gets its turn.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = GW'((int'(r_last) + k) % NREQ);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == GW'(i)) begin
                w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_retry_inc = 1'b0;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !w_blocked) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (fifo_wr_ack) begin
                    w_done_nxt  = ONE_HOT0 << r_gnt;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_retry_inc = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_blocked) begin
                    w_state_nxt = S_WRITE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= GW'(NREQ - 1);
            r_data  <= '0;
            r_done  <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_gnt  <= w_sel;
                r_last <= w_sel;
                r_data <= w_word;
            end
            if (w_retry_inc && (r_retry != 8'hFF)) begin
                r_retry <= r_retry + 8'd1;
            end
        end
    end

    assign req_done     = r_done;
    assign gnt_id       = r_gnt;
    assign busy         = (r_state != S_IDLE);
    assign retry_cnt    = r_retry;
    assign fifo_data_in = r_data;
    assign fifo_wr_en   = (r_state == S_WRITE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a cycle-counting reference model with a FIFO stand-in.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_done;
    logic [1:0]           gnt_id;
    logic                 busy;
    logic [7:0]           retry_cnt;
    logic [DW-1:0]        fifo_data_in;
    logic                 fifo_wr_en;
    logic                 fifo_full;
    logic                 fifo_almostfull;
    logic                 fifo_wr_ack;
    logic [1:0]           dbg_state;
    logic                 force_reject;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_done(req_done),
        .gnt_id(gnt_id), .busy(busy), .retry_cnt(retry_cnt), .fifo_data_in(fifo_data_in),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack(fifo_wr_ack), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // FIFO stand-in: ack is registered, high when an offered word was accepted.
    always @(posedge clk) begin
        if (rst) fifo_wr_ack <= 1'b0;
        else     fifo_wr_ack <= fifo_wr_en & ~fifo_full & ~force_reject;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [DW-1:0] w);
        req_data = (req_data & ~(64'hFFFF << (i * DW))) | (64'(w) << (i * DW));
    endtask

    // Reference model: one pending write at a time; an attempt issued at edge e is
    // judged by the ack seen at edge e+2; a rejected attempt waits until not blocked.
    int               cyc;
    int               m_last, m_id, m_gnt, m_wr_edge, m_retry;
    bit               m_busy, m_stalled, e_wr;
    logic [NREQ-1:0]  e_done;
    logic [DW-1:0]    m_word;

    task automatic model_reset();
        cyc = 0; m_last = NREQ - 1; m_id = 0; m_gnt = 0; m_wr_edge = -10; m_retry = 0;
        m_busy = 0; m_stalled = 0; e_wr = 0; e_done = '0; m_word = '0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] elig;
        logic [NREQ-1:0] nd;
        bit              blk;
        bit              found;
        int              idx;
        blk = fifo_full;
`ifdef FIFO_ARB_ALMOSTFULL_THROTTLE_EN
        blk = fifo_full | fifo_almostfull;
`endif
        nd   = '0;
        e_wr = 0;
        if (!m_busy) begin
            elig = req & ~e_done;
            if (elig != 0 && !blk) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (!found && elig[2'(idx)]) begin
                        found = 1;
                        m_id  = idx;
                    end
                end
                m_last    = m_id;
                m_gnt     = m_id;
                m_word    = DW'(req_data >> (m_id * DW));
                m_busy    = 1;
                m_stalled = 0;
                e_wr      = 1;
                m_wr_edge = cyc;
            end
        end else if (m_stalled) begin
            if (!blk) begin
                e_wr      = 1;
                m_stalled = 0;
                m_wr_edge = cyc;
            end
        end else if (cyc - m_wr_edge == 2) begin
            if (fifo_wr_ack) begin
                nd[2'(m_id)] = 1'b1;
                m_busy       = 0;
            end else begin
                if (m_retry < 255) m_retry++;
                m_stalled = 1;
            end
        end
        e_done = nd;
        cyc++;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        int              exp_gnt;
    } vec_t;

    vec_t            vecs[9];
    logic [DW-1:0]   exp_word;
    logic [NREQ-1:0] got;
    int              fifo_count;

    initial begin
        vecs[0] = '{4'b0010, 1};
        vecs[1] = '{4'b1111, 2};
        vecs[2] = '{4'b1111, 3};
        vecs[3] = '{4'b1111, 0};
        vecs[4] = '{4'b0001, 0};
        vecs[5] = '{4'b1000, 3};
        vecs[6] = '{4'b0110, 1};
        vecs[7] = '{4'b0101, 2};
        vecs[8] = '{4'b0011, 0};

        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
        fifo_almostfull = 1'b0; force_reject = 1'b0;
        @(negedge clk);
        tick(); tick();
        check("rst_done", req_done, 0);
        check("rst_gnt", gnt_id, 0);
        check("rst_busy", busy, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_data", fifo_data_in, 0);
        rst = 1'b0;
        tick();

        // Directed single transactions; grant order follows round-robin from last grant.
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < NREQ; i++) set_word(i, DW'(16'h1100 * i + v));
            if (v == 0) set_word(1, 16'hA5A5);
            exp_word = (v == 0) ? 16'hA5A5 : DW'(16'h1100 * vecs[v].exp_gnt + v);
            req = vecs[v].req;
            tick();
            check("vec_wr_en", fifo_wr_en, 1);
            check("vec_data", fifo_data_in, exp_word);
            check("vec_gnt", gnt_id, vecs[v].exp_gnt);
            check("vec_busy", busy, 1);
            tick();
            check("vec_check_wr_en", fifo_wr_en, 0);
            tick();
            check("vec_done", req_done, 4'b0001 << vecs[v].exp_gnt);
            check("vec_idle", busy, 0);
            req = '0;
            tick();
            check("vec_done_pulse", req_done, 0);
        end

        // Reset in the middle of a write abandons it.
        req = 4'b0100; set_word(2, 16'hBEEF);
        tick();
        check("mid_wr_en", fifo_wr_en, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_wr_en", fifo_wr_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gnt", gnt_id, 0);
        check("mid_rst_data", fifo_data_in, 0);
        check("mid_rst_done", req_done, 0);
        check("mid_rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();
        check("post_rst_gnt2", gnt_id, 2);
        check("post_rst_data", fifo_data_in, 16'hBEEF);
        tick(); tick();
        check("post_rst_done2", req_done, 4'b0100);
        req = '0;
        tick();
        rst = 1'b1; req = 4'b0101; set_word(0, 16'h0F0F);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_gnt0", gnt_id, 0);
        check("post_rst_data0", fifo_data_in, 16'h0F0F);
        tick(); tick();
        check("post_rst_done0", req_done, 4'b0001);
        req = '0;
        tick();

        // Full FIFO blocks the grant; a rejected write waits and retries the locked word.
        fifo_full = 1'b1; req = 4'b1000; set_word(3, 16'h3C3C);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("full_no_wr", fifo_wr_en, 0);
            check("full_no_busy", busy, 0);
        end
        fifo_full = 1'b0; force_reject = 1'b1;
        tick();
        check("retry_wr_en", fifo_wr_en, 1);
        check("retry_gnt", gnt_id, 3);
        check("retry_data", fifo_data_in, 16'h3C3C);
        fifo_full = 1'b1;
        tick();
        check("retry_check_state", dbg_state, 2);
        force_reject = 1'b0;
        tick();
        check("retry_wait_state", dbg_state, 3);
        check("retry_cnt1", retry_cnt, 1);
        set_word(3, 16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wait_no_wr", fifo_wr_en, 0);
            check("wait_state", dbg_state, 3);
        end
        fifo_full = 1'b0;
        tick();
        check("rewrite_wr_en", fifo_wr_en, 1);
        check("rewrite_data", fifo_data_in, 16'h3C3C);
        tick(); tick();
        check("rewrite_done", req_done, 4'b1000);
        check("rewrite_retry", retry_cnt, 1);
        req = '0;
        tick();

        // Almostfull throttling only in the macro build.
        fifo_almostfull = 1'b1; req = 4'b0001; set_word(0, 16'h7777);
`ifdef FIFO_ARB_ALMOSTFULL_THROTTLE_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check("afull_no_wr", fifo_wr_en, 0);
            check("afull_no_busy", busy, 0);
        end
        fifo_almostfull = 1'b0;
`endif
        tick();
        check("afull_wr_en", fifo_wr_en, 1);
        check("afull_data", fifo_data_in, 16'h7777);
        tick(); tick();
        check("afull_done", req_done, 4'b0001);
        req = '0; fifo_almostfull = 1'b0;
        tick();

        // Saturation of the retry counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_clear", retry_cnt, 0);
        req = 4'b0010; force_reject = 1'b1;
        for (int k = 0; k < 910; k++) tick();
        check("sat_255", retry_cnt, 255);
        check("sat_busy", busy, 1);
        force_reject = 1'b0;
        got = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req_done != 0) begin
                got = req_done;
                break;
            end
        end
        check("sat_done", got, 4'b0010);
        check("sat_hold", retry_cnt, 255);
        req = '0;
        tick();

        // Random traffic against the reference model.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        fifo_count = 0;
        for (int c = 0; c < 2000; c++) begin
            force_reject = ($urandom_range(0, 7) == 0);
            if (fifo_count > 0 && $urandom_range(0, 3) == 0) fifo_count--;
            fifo_full       = (fifo_count == 8);
            fifo_almostfull = (fifo_count >= 7);
            for (int i = 0; i < NREQ; i++) begin
                if (req_done[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    if (req[i]) set_word(i, DW'($urandom));
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_word(i, DW'($urandom));
                end else if (req[i] && $urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    set_word(i, DW'($urandom));
                end
            end
            model_step();
            tick();
            check("rnd_done", req_done, e_done);
            check("rnd_wr_en", fifo_wr_en, e_wr);
            if (e_wr) check("rnd_data", fifo_data_in, m_word);
            check("rnd_gnt", gnt_id, m_gnt);
            check("rnd_busy", busy, m_busy);
            check("rnd_retry", retry_cnt, m_retry);
            if (fifo_wr_ack) fifo_count++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
